coin_acceptor: RTL and testbench

Front-end stage for the vending FSM. It conditions three raw, asynchronous, bouncy coin-sensor lines into clean, mutually exclusive, single-cycle nickel/dime/quarter pulses. Its outputs drive the FSM's nickel, dime and quarter inputs directly. Invalid insertions (several sensors at once, or a coin while acceptance is disabled) produce a reject pulse instead of credit.

---
 rtl/coin_pkg.sv | 27 ++
 rtl/coin_debounce.sv | 59 +++++
 rtl/coin_acceptor.sv | 115 +++++++++++
 tb/tb_coin_acceptor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor front end: sensor bit positions,
// coin values and the acceptor state encoding.
package coin_pkg;

  localparam int COIN_W      = 3;
  localparam int NICKEL_IDX  = 0;
  localparam int DIME_IDX    = 1;
  localparam int QUARTER_IDX = 2;

  localparam int NICKEL_VAL  = 5;
  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT    = 3'd1,
    REJECT  = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } coin_state_e;

  // True when exactly one sensor bit is set.
  function automatic logic is_onehot(input logic [COIN_W-1:0] v);
    return (v != {COIN_W{1'b0}}) && ((v & (v - COIN_W'(1))) == {COIN_W{1'b0}});
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Synchronizes the raw sensor vector into clk and filters it with a single
// whole-vector stability counter.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COIN_W-1:0] raw_vec,
  output logic [COIN_W-1:0] deb_vec
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [COIN_W-1:0] sync_r [SYNC_STAGES];
  logic [COIN_W-1:0] sync_vec_s;
  logic [COIN_W-1:0] deb_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sync_moving_s;

  assign sync_vec_s    = sync_r[SYNC_STAGES-1];
  // sync_vec is about to take a new value on this edge
  assign sync_moving_s = (sync_r[SYNC_STAGES-2] != sync_vec_s);
  assign deb_vec       = deb_r;

  // Metastability chain, one flop per stage per sensor bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {COIN_W{1'b0}};
      end
    end else begin
      sync_r[0] <= raw_vec;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // The final qualifying edge wins even if sync_vec moves on the same edge,
  // so a pulse lasting exactly DEBOUNCE_CYCLES still gets through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_r <= {COIN_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if ((sync_vec_s != deb_r) && (cnt_r == CNT_LAST)) begin
      deb_r <= sync_vec_s;
      cnt_r <= {CNT_W{1'b0}};
    end else if ((sync_vec_s == deb_r) || sync_moving_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounced sensor vector feeding a small FSM that
// emits one clean credit or reject pulse per inserted coin.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COIN_W-1:0] coin_raw,
  input  logic              accept_en,
  output logic              nickel,
  output logic              dime,
  output logic              quarter,
  output logic              coin_reject,
  output logic              busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [COIN_W-1:0] deb_vec_s;
  coin_state_e       state_r;
  coin_state_e       next_state_s;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              gap_done_s;
  logic [COIN_W-1:0] emit_s;
  logic              reject_s;

  coin_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .raw_vec (coin_raw),
    .deb_vec (deb_vec_s)
  );

  assign gap_done_s = (gap_cnt_r == GAP_LAST);

  // Next-state and pulse decode; accept_en only matters on the IDLE decision
  always_comb begin
    next_state_s = state_r;
    emit_s       = {COIN_W{1'b0}};
    reject_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (deb_vec_s != {COIN_W{1'b0}}) begin
          if (is_onehot(deb_vec_s) && accept_en) begin
            next_state_s = EMIT;
            emit_s       = deb_vec_s;
          end else begin
            next_state_s = REJECT;
            reject_s     = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT:    next_state_s = RELEASE;
      REJECT:  next_state_s = RELEASE;
      RELEASE: begin
        if (deb_vec_s == {COIN_W{1'b0}}) begin
          next_state_s = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          next_state_s = RELEASE;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and idle-gap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if ((state_r == GAP) && !gap_done_s) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      nickel      <= emit_s[NICKEL_IDX];
      dime        <= emit_s[DIME_IDX];
      quarter     <= emit_s[QUARTER_IDX];
      coin_reject <= reject_s;
      busy        <= (next_state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed plus randomized bench for coin_acceptor, checked every cycle
// against a sample-history reference model.
module tb_coin_acceptor;

  localparam int S = 2;
  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coin_raw;
  logic       accept_en;
  logic       nickel, dime, quarter, coin_reject, busy;

  int tests = 0;
  int fails = 0;

  coin_acceptor #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .GAP_CYCLES      (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_raw    (coin_raw),
    .accept_en   (accept_en),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples since reset; the filtered vector adopts a
  // value once the synchronized stream has shown it for D straight edges.
  logic [2:0] hist[$];
  logic [2:0] m_deb;
  bit         m_holding;   // coin accepted or rejected, waiting for removal
  bit         m_pulsed;    // pulse cycle just happened
  int         m_gap;       // idle cycles still owed after removal
  logic [4:0] m_out;       // {busy, reject, quarter, dime, nickel}

  string phase_tag;
  int    scen_edge, first_pulse_edge;
  int    pc_n, pc_d, pc_q, pc_r;

  function automatic logic [2:0] sync_at(int t);
    if (t - S >= 1) return hist[t-S-1];
    return 3'b000;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_deb     = 3'b000;
    m_holding = 1'b0;
    m_pulsed  = 1'b0;
    m_gap     = 0;
    m_out     = 5'b00000;
  endfunction

  function automatic void model_step(logic [2:0] raw, logic acc);
    int         t;
    logic [2:0] v;
    bit         settle;
    hist.push_back(raw);
    t     = hist.size();
    m_out = 5'b00000;
    if (m_pulsed) begin
      m_pulsed = 1'b0;
    end else if (m_holding) begin
      if (m_deb == 3'b000) begin
        m_holding = 1'b0;
        m_gap     = G;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (m_deb != 3'b000) begin
      if ($countones(m_deb) == 1 && acc) m_out[2:0] = m_deb;
      else m_out[3] = 1'b1;
      m_pulsed  = 1'b1;
      m_holding = 1'b1;
    end
    m_out[4] = m_pulsed || m_holding || (m_gap > 0);
    v      = sync_at(t);
    settle = (v != m_deb);
    for (int k = 1; k < D; k++) begin
      if (sync_at(t - k) != v) settle = 1'b0;
    end
    if (settle) m_deb = v;
  endfunction

  task automatic check_out(string tag);
    logic [4:0] obs;
    obs = {busy, coin_reject, quarter, dime, nickel};
    tests++;
    assert (obs === m_out) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, m_out);
    end
    tests++;
    assert ($countones(obs[3:0]) <= 1) else begin
      fails++;
      $error("FAIL %s_exclusive: observed %b expected at most one pulse", tag, obs[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(coin_raw, accept_en);
    @(negedge clk);
    check_out(phase_tag);
    scen_edge++;
    if ((nickel || dime || quarter || coin_reject) && first_pulse_edge == 0)
      first_pulse_edge = scen_edge;
    pc_n += int'(nickel);
    pc_d += int'(dime);
    pc_q += int'(quarter);
    pc_r += int'(coin_reject);
  endtask

  task automatic run(logic [2:0] v, int n);
    coin_raw = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic begin_scen(string tag);
    phase_tag        = tag;
    scen_edge        = 0;
    first_pulse_edge = 0;
    pc_n = 0; pc_d = 0; pc_q = 0; pc_r = 0;
  endtask

  task automatic expect_int(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_out("reset_async");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_out("in_reset");
    end
    reset = 1'b0;
  endtask

  initial begin
    coin_raw  = 3'b000;
    accept_en = 1'b1;
    phase_tag = "init";
    do_reset();

    begin_scen("quarter");
    run(3'b100, 12);
    expect_int("quarter_edge", first_pulse_edge, 7);
    run(3'b000, 16);
    expect_int("quarter_count", pc_q, 1);
    expect_int("quarter_others", pc_n + pc_d + pc_r, 0);

    begin_scen("glitch3");
    run(3'b001, 3);
    run(3'b000, 12);
    expect_int("glitch3_pulses", pc_n + pc_d + pc_q + pc_r, 0);

    begin_scen("glitch4");
    run(3'b001, 4);
    run(3'b000, 16);
    expect_int("glitch4_nickel", pc_n, 1);

    begin_scen("multihot");
    run(3'b011, 10);
    run(3'b000, 16);
    expect_int("multihot_reject", pc_r, 1);
    expect_int("multihot_credit", pc_n + pc_d, 0);

    begin_scen("disabled");
    accept_en = 1'b0;
    run(3'b010, 8);
    accept_en = 1'b1;
    run(3'b010, 6);
    run(3'b000, 16);
    expect_int("disabled_reject", pc_r, 1);
    expect_int("disabled_dime", pc_d, 0);

    begin_scen("back2back");
    run(3'b001, 8);
    run(3'b000, 6);
    run(3'b010, 12);
    run(3'b000, 16);
    expect_int("b2b_nickel", pc_n, 1);
    expect_int("b2b_dime", pc_d, 1);

    begin_scen("reset_mid");
    run(3'b100, 3);
    do_reset();
    begin_scen("after_reset");
    run(3'b100, 12);
    expect_int("after_reset_edge", first_pulse_edge, 7);
    expect_int("after_reset_quarter", pc_q, 1);
    run(3'b000, 16);

    begin_scen("random");
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        accept_en = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 2) == 0) run(3'b000, $urandom_range(1, 12));
        else if ($urandom_range(0, 1) == 0) run(3'(1 << $urandom_range(0, 2)), $urandom_range(1, 12));
        else run(3'($urandom_range(0, 7)), $urandom_range(1, 12));
      end
    end
    run(3'b000, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
